// File: rtl/norm_shift.sv
// norm_shift -- iterative block-floating-point normalizer.
//
// Takes a 2W-bit signed value and finds the smallest arithmetic right-shift
// count sh (0..W-1) for which the value fits in a W-bit signed mantissa.
// It returns that mantissa and sh, so barrel(out, sh) rebuilds the input with
// its low sh bits cleared. If the value does not fit even at shift W-1, the
// mantissa saturates to the most positive or most negative value and sat is set.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The input side accepts only in IDLE. The output side holds out,
// sh and sat stable in DONE until out_ready is seen. in_ready and out_valid
// are decoded from the state register only.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous, active-high reset
//   in         - 2W-bit signed value to normalize
//   in_valid   - in is valid
//   in_ready   - block can accept a new input (state == IDLE)
//   out        - W-bit signed mantissa (registered)
//   sh         - right-shift count (registered)
//   sat        - result saturated (registered)
//   out_valid  - out/sh/sat are valid (state == DONE)
//   out_ready  - consumer takes the result
module norm_shift #(
    parameter int W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2*W-1:0]       in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [W-1:0]         out,
    output logic [$clog2(W)-1:0] sh,
    output logic                 sat,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int SW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [2*W-1:0]  acc, acc_nx;
    logic [SW-1:0]   cnt, cnt_nx;
    logic [W-1:0]    out_nx;
    logic [SW-1:0]   sh_nx;
    logic            sat_nx;

    // The value fits in W signed bits when the top W+1 bits are all copies
    // of the sign bit.
    logic [W:0]      top;
    logic            fits;

    assign top  = acc[2*W-1:W-1];
    assign fits = (&top) | ~(|top);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        out_nx   = out;
        sh_nx    = sh;
        sat_nx   = sat;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    acc_nx   = in;
                    cnt_nx   = '0;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (fits) begin
                    out_nx   = acc[W-1:0];
                    sh_nx    = cnt;
                    sat_nx   = 1'b0;
                    state_nx = DONE;
                end else if (cnt == SW'(W - 1)) begin
                    // Still too wide at the maximum shift: clamp by sign.
                    out_nx   = acc[2*W-1] ? {1'b1, {(W-1){1'b0}}}
                                          : {1'b0, {(W-1){1'b1}}};
                    sh_nx    = SW'(W - 1);
                    sat_nx   = 1'b1;
                    state_nx = DONE;
                end else begin
                    // Sign-filled shift: truncation toward minus infinity.
                    acc_nx = {acc[2*W-1], acc[2*W-1:1]};
                    cnt_nx = cnt + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            out   <= '0;
            sh    <= '0;
            sat   <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            out   <= out_nx;
            sh    <= sh_nx;
            sat   <= sat_nx;
        end
    end

endmodule

// File: tb/tb_norm_shift.sv
// tb_norm_shift -- self-checking bench for norm_shift.
//
// Directed cases exercise round trip, minimal shift, no shift, lossy shift,
// saturation, back-pressure, ignored input during BUSY and reset mid-operation.
// Randomized values of varying magnitude follow. Expected results come from a
// range-based reference model: the smallest shift whose shifted value lies in
// the W-bit signed range.
module tb_norm_shift;

    localparam int W  = 16;
    localparam int SW = $clog2(W);

    // ---------------- clock / reset / DUT ----------------
    logic                clk = 1'b0;
    logic                reset;
    logic [2*W-1:0]      in;
    logic                in_valid;
    logic                in_ready;
    logic [W-1:0]        out;
    logic [SW-1:0]       sh;
    logic                sat;
    logic                out_valid;
    logic                out_ready;

    always #5 clk = ~clk;

    norm_shift #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .sh        (sh),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W+SW:0] exp_q[$];   // {sat, sh, out}

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: smallest k with (x >>> k) inside [-2^(W-1), 2^(W-1)).
    function automatic logic [W+SW:0] model(input logic [2*W-1:0] v);
        longint x;
        longint y;
        longint lo;
        longint hi;
        logic [W-1:0]  m;
        logic [SW-1:0] s;
        bit            st;
        bit            found;
        x     = $signed(v);
        lo    = -(longint'(1) << (W - 1));
        hi    = longint'(1) << (W - 1);
        found = 1'b0;
        st    = 1'b0;
        m     = '0;
        s     = '0;
        for (int k = 0; k < W; k++) begin
            y = x >>> k;
            if (!found && y >= lo && y < hi) begin
                found = 1'b1;
                m     = y[W-1:0];
                s     = SW'(k);
            end
        end
        if (!found) begin
            st = 1'b1;
            s  = SW'(W - 1);
            m  = (x < 0) ? W'(lo) : W'(hi - 1);
        end
        return {st, s, m};
    endfunction

    // ---------------- driver ----------------
    // hold: cycles with out_ready low in DONE; poke: in_valid pulse during BUSY.
    task automatic run_one(input logic [2*W-1:0] v, input int hold, input bit poke);
        logic [W+SW:0] e;
        logic [W-1:0]  em;
        logic [SW-1:0] es;
        logic          est;
        int            lat;
        longint        rec;
        longint        want;
        out_ready = (hold == 0);
        check_eq("in_ready_idle", in_ready, 1);
        in       = v;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in       = $urandom;
        exp_q.push_back(model(v));
        lat = 0;
        while (!out_valid && lat < 40) begin
            in_valid = poke && (lat == 1);
            in       = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        e = exp_q.pop_front();
        {est, es, em} = e;
        check_eq("latency", lat, es + 1);
        check_eq("out", out, em);
        check_eq("sh", sh, es);
        check_eq("sat", sat, est);
        check_eq("in_ready_done", in_ready, 0);
        if (!est) begin
            rec  = longint'($signed(out)) <<< sh;
            want = longint'($signed(v)) & ~((longint'(1) << es) - 1);
            check_eq("barrel_roundtrip", rec, want);
        end
        repeat (hold) begin
            @(posedge clk); #1;
            check_eq("hold_stable", {out_valid, in_ready, sat, sh, out},
                     {1'b1, 1'b0, est, es, em});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("handoff_valid", out_valid, 0);
        check_eq("in_ready_after", in_ready, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2*W-1:0] v;
        int             k;
        int             hold;
        bit             seen;

        reset     = 1'b1;
        in        = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out", out, 0);
        check_eq("rst_sh", sh, 0);
        check_eq("rst_sat", sat, 0);

        run_one(32'hFFFABCD0, 0, 1'b0);
        run_one(32'h01234000, 0, 1'b0);
        run_one(32'h00001234, 0, 1'b0);
        run_one(32'hFFFF8000, 0, 1'b0);
        run_one(32'h00012345, 0, 1'b0);
        run_one(32'h7FFFFFFF, 0, 1'b0);
        run_one(32'h80000000, 0, 1'b0);
        run_one(32'hFFFABCD0, 10, 1'b1);
        run_one(32'h00000000, 3, 1'b1);

        // Reset on the fifth BUSY cycle of a saturating operation.
        out_ready = 1'b1;
        in        = 32'h7FFFFFFF;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("mid_rst_in_ready", in_ready, 1);
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_out", out, 0);
        check_eq("mid_rst_sh", sh, 0);
        check_eq("mid_rst_sat", sat, 0);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check_eq("no_valid_after_rst", seen, 0);
        run_one(32'hFFFABCD0, 0, 1'b0);

        // Random values spread over all shift amounts.
        repeat (40) begin
            v    = $urandom;
            k    = $urandom_range(0, 31);
            v    = $signed(v) >>> k;
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            run_one(v, hold, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
